// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - credit-based FIFO read adapter with 4-entry skid buffer and valid/ready output
// Optional word/stall counters are built only when FIFO_READER_STATS_EN is defined.
module fifo_stream_reader #(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       word_cnt_o,
  output logic [31:0]       stall_cnt_o
);

  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DWIDTH-1:0] buf_q [4];
  logic [DWIDTH-1:0] buf_d [4];
  logic              capture;
  logic              pop;
  logic              valid;

  // Credit counts buffered words plus the one possibly returning from the FIFO,
  // so every issued read is guaranteed a free slot when its data lands.
  assign valid        = (occ_q != 3'd0);
  assign fifo_rdreq_o = rst_n_i & ~fifo_empty_i & ~flush_i &
                        (({1'b0, occ_q} + {3'b000, inflight_q}) < 4'd4);
  assign capture      = inflight_q & ~flush_i;
  assign pop          = valid & out_ready_i;
  assign out_valid_o  = valid;
  assign out_data_o   = valid ? buf_q[rd_ptr_q] : '0;

  always_comb begin
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = fifo_rdreq_o;
    if (flush_i) begin
      wr_ptr_d   = 2'd0;
      rd_ptr_d   = 2'd0;
      occ_d      = 3'd0;
      inflight_d = 1'b0;
    end else begin
      if (capture) begin
        buf_d[wr_ptr_q] = fifo_q_i;
        wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end
      occ_d = occ_q + {2'b00, capture} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      occ_q      <= 3'd0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage needs no reset: the output is masked whenever occupancy is zero.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

`ifdef FIFO_READER_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    word_cnt_d  = word_cnt_q + {31'd0, pop};
    stall_cnt_d = stall_cnt_q + {31'd0, valid & ~out_ready_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_cnt_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_cnt_o  = word_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign word_cnt_o  = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed and table-driven bench for fifo_stream_reader
// Expected counter values follow FIFO_READER_STATS_EN as defined for the build.
module tb_fifo_stream_reader;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  fifo_q_i = 8'd0;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rdreq_o;
  logic        flush_i = 1'b0;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] word_cnt_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int failures = 0;
  int rd_empty = 0;
  logic [7:0] fq[$];

  fifo_stream_reader #(.DWIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .fifo_q_i    (fifo_q_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_rdreq_o(fifo_rdreq_o),
    .flush_i     (flush_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .word_cnt_o  (word_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Normal-mode FIFO model: data appears the cycle after the read request.
  always @(posedge clk_i) begin
    if (fifo_rdreq_o) begin
      if (fq.size() == 0) begin
        rd_empty++;
      end else begin
        fifo_q_i <= fq.pop_front();
        fifo_empty_i <= (fq.size() == 0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    out_ready_i = 1'b0;
    flush_i = 1'b0;
    fq.delete();
    fifo_empty_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'(first + i));
    fifo_empty_i = (fq.size() == 0);
  endtask

  task automatic drive(input logic rdy, input logic fl);
    out_ready_i = rdy;
    flush_i = fl;
    #1;
  endtask

  typedef struct {
    logic       rdy;
    logic       fl;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_rdreq;
  } vec_t;

  vec_t tbl[19];
  int exp_words;
  int exp_stalls;

  initial begin
    int rd_pulses;
    int first_rd;
    int first_v;
    int n;
    int requested;
    int popped;
    int bad_credit;
    logic rdy;
    logic [7:0] expq[$];
    logic [7:0] got[$];

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1};
    for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 8'h05, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 8'h06, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    // Reset state, with the FIFO already holding data to prove rdreq is gated
    @(negedge clk_i);
    fq.push_back(8'hAA);
    fifo_empty_i = 1'b0;
    #1;
    chk("reset_rdreq", fifo_rdreq_o, 1'b0);
    chk("reset_valid", out_valid_o, 1'b0);
    chk("reset_data", out_data_o, 8'h00);
    chk("reset_word_cnt", word_cnt_o, 32'd0);
    chk("reset_stall_cnt", stall_cnt_o, 32'd0);

    // Back-pressure table: 8 words, ready low for 10 cycles, then drain
    do_reset();
    push_seq(1, 8);
    rd_pulses = 0;
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl_valid[%0d]", i), out_valid_o, tbl[i].exp_valid);
      chk($sformatf("tbl_data[%0d]", i), out_data_o, tbl[i].exp_data);
      chk($sformatf("tbl_rdreq[%0d]", i), fifo_rdreq_o, tbl[i].exp_rdreq);
      if (i < 10 && fifo_rdreq_o) rd_pulses++;
      @(negedge clk_i);
    end
    chk("bp_rd_pulses", rd_pulses, 4);
`ifdef FIFO_READER_STATS_EN
    exp_words = 8; exp_stalls = 8;
`else
    exp_words = 0; exp_stalls = 0;
`endif
    chk("bp_word_cnt", word_cnt_o, exp_words);
    chk("bp_stall_cnt", stall_cnt_o, exp_stalls);

    // Streaming: 16 words with ready high, no bubbles
    do_reset();
    push_seq(1, 16);
    first_rd = -1; first_v = -1; n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      drive(1'b1, 1'b0);
      if (fifo_rdreq_o && first_rd < 0) first_rd = cyc;
      if (out_valid_o) begin
        if (first_v < 0) first_v = cyc;
        chk($sformatf("stream_data[%0d]", n), out_data_o, 8'(n + 1));
        chk($sformatf("stream_cycle[%0d]", n), cyc, first_v + n);
        n++;
      end
      @(negedge clk_i);
    end
    chk("stream_first_rdreq", first_rd, 0);
    chk("stream_latency", first_v - first_rd, 2);
    chk("stream_count", n, 16);

    // Random ready over 1000 random words
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      fq.push_back(w);
      expq.push_back(w);
    end
    fifo_empty_i = 1'b0;
    requested = 0; popped = 0; bad_credit = 0;
    for (int cyc = 0; cyc < 6000 && popped < 1000; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      drive(rdy, 1'b0);
      if (fifo_rdreq_o) requested++;
      if (out_valid_o && rdy) begin
        chk($sformatf("rand_data[%0d]", popped), out_data_o, expq.pop_front());
        popped++;
      end
      if (requested - popped > 4) bad_credit++;
      @(negedge clk_i);
    end
    chk("rand_count", popped, 1000);
    chk("rand_outstanding_over_4", bad_credit, 0);

    // Flush with occ=3 and one read in flight
    do_reset();
    push_seq(1, 8);
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(1'b0, 1'b0);
      @(negedge clk_i);
    end
    drive(1'b0, 1'b1);
    chk("flush_rdreq_forced", fifo_rdreq_o, 1'b0);
    @(negedge clk_i);
    got.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive(1'b1, 1'b0);
      if (cyc == 0) chk("flush_valid_low", out_valid_o, 1'b0);
      if (out_valid_o) got.push_back(out_data_o);
      @(negedge clk_i);
    end
    chk("flush_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      chk($sformatf("flush_data[%0d]", i), g, 8'(5 + i));
    end
`ifdef FIFO_READER_STATS_EN
    exp_words = 4; exp_stalls = 3;
`else
    exp_words = 0; exp_stalls = 0;
`endif
    chk("flush_word_cnt", word_cnt_o, exp_words);
    chk("flush_stall_cnt", stall_cnt_o, exp_stalls);

    // Statistics: 20 pops, ready low for the first 9 cycles gives 7 stalls
    do_reset();
    push_seq(1, 20);
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive(cyc >= 9, 1'b0);
      @(negedge clk_i);
    end
`ifdef FIFO_READER_STATS_EN
    exp_words = 20; exp_stalls = 7;
`else
    exp_words = 0; exp_stalls = 0;
`endif
    chk("stats_word_cnt", word_cnt_o, exp_words);
    chk("stats_stall_cnt", stall_cnt_o, exp_stalls);

    // Asynchronous reset between clock edges
    do_reset();
    push_seq(1, 8);
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive(1'b1, 1'b0);
      if (cyc < 3) @(negedge clk_i);
    end
    chk("async_pre_valid", out_valid_o, 1'b1);
    chk("async_pre_rdreq", fifo_rdreq_o, 1'b1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("async_valid", out_valid_o, 1'b0);
    chk("async_rdreq", fifo_rdreq_o, 1'b0);
    chk("async_data", out_data_o, 8'h00);
    chk("async_word_cnt", word_cnt_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    drive(1'b1, 1'b0);
    chk("async_release_rdreq", fifo_rdreq_o, 1'b1);
    @(negedge clk_i);

    chk("never_read_empty", rd_empty, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
